// File: rtl/ap_ctrl_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ap_seq_pkg
// Purpose  : Shared types and defaults for the ap_ctrl_chain sequencer.
//            seq_state_t - sequencer FSM state encoding
//            c_def_cnt_w - default width of counters, timestamps, latencies
// Revision : 1.0 - initial release
// ============================================================================
package ap_seq_pkg;

    localparam int c_def_cnt_w = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage : ap_seq_pkg
`default_nettype wire

// File: rtl/ap_ctrl_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ap_ctrl_sequencer_if
// Purpose  : Block-level ap_ctrl_chain handshake between a sequencer and an
//            HLS kernel.
//            ap_start    - start request            (sequencer -> kernel)
//            ap_ready    - inputs accepted          (kernel -> sequencer)
//            ap_done     - result valid             (kernel -> sequencer)
//            ap_continue - result consumed          (sequencer -> kernel)
//            modport master : sequencer side, modport slave : kernel side
// Revision : 1.0 - initial release
// ============================================================================
interface ap_ctrl_sequencer_if;

    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;

    modport master (
        output ap_start,
        output ap_continue,
        input  ap_ready,
        input  ap_done
    );

    modport slave (
        input  ap_start,
        input  ap_continue,
        output ap_ready,
        output ap_done
    );

endinterface : ap_ctrl_sequencer_if
`default_nettype wire

// File: rtl/ap_ctrl_sequencer_ts_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ts_fifo
// Purpose  : Small synchronous FIFO holding start timestamps of outstanding
//            transactions. The head entry is visible combinationally so the
//            retire logic can compute latency in the same cycle it pops.
// Ports    : clock, reset (async, active-low)
//            clear          - synchronous flush (pointers and count to zero)
//            push/push_data - write one entry (ignored when full)
//            pop            - discard head entry (ignored when empty)
//            head           - current head entry
//            full/empty/count - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module ts_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    assign full  = (r_count == (c_aw + 1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clock) begin
        if (w_push_ok && !clear) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule : ts_fifo
`default_nettype wire

// File: rtl/ap_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ap_ctrl_sequencer
// Purpose  : Drives the ap_ctrl_chain handshake of an HLS kernel. On go it
//            issues num_trans starts (at most MAX_OUT outstanding), applies
//            sink backpressure through ap_continue, measures start-to-done
//            latency per transaction and raises finish once all retired.
// Ports    : clock, reset (async, active-low)
//            go, num_trans    - run request and transaction count
//            sink_ready       - downstream can take a result
//            bus (master)     - ap_start/ap_ready/ap_done/ap_continue
//            busy, finish     - RUN|DRAIN, DONE
//            start_cnt, done_cnt, cycle_cnt - run statistics
//            min_lat, max_lat - latency extremes over retired transactions
//            err              - sticky: ap_done retired with none outstanding
// Revision : 1.0 - initial release
// ============================================================================
module ap_ctrl_sequencer
    import ap_seq_pkg::*;
#(
    parameter int CNT_W   = c_def_cnt_w,
    parameter int MAX_OUT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 go,
    input  logic [CNT_W-1:0]     num_trans,
    input  logic                 sink_ready,
    ap_ctrl_sequencer_if.master  bus,
    output logic                 busy,
    output logic                 finish,
    output logic [CNT_W-1:0]     start_cnt,
    output logic [CNT_W-1:0]     done_cnt,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     min_lat,
    output logic [CNT_W-1:0]     max_lat,
    output logic                 err
);

    localparam int c_occ_w = $clog2(MAX_OUT) + 1;

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;

    logic [CNT_W-1:0]   r_num_q;
    logic [CNT_W-1:0]   r_start_cnt;
    logic [CNT_W-1:0]   r_done_cnt;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   r_min_lat;
    logic [CNT_W-1:0]   r_max_lat;
    logic               r_err;

    logic               w_active;
    logic               w_go_ok;
    logic               w_ap_start;
    logic               w_ap_continue;
    logic               w_accept;
    logic               w_retire_req;
    logic               w_retire;
    logic               w_retire_err;
    logic               w_start_last;
    logic               w_done_last;
    logic [CNT_W-1:0]   w_head_ts;
    logic [CNT_W-1:0]   w_lat;
    logic [c_occ_w-1:0] w_count;
    logic               w_empty;
    logic               w_full_unused;

    // ------------------------------------------------------------------
    // Handshake decode. ap_start depends on registers only, so a kernel
    // that ties ap_ready to ap_start cannot form a combinational loop.
    // ------------------------------------------------------------------
    assign w_active      = (r_state == RUN) || (r_state == DRAIN);
    assign w_go_ok       = go && ((r_state == IDLE) || (r_state == DONE));
    assign w_ap_start    = (r_state == RUN) && (r_start_cnt < r_num_q)
                           && (w_count < c_occ_w'(MAX_OUT));
    assign w_ap_continue = w_active && sink_ready;

    assign w_accept      = w_ap_start && bus.ap_ready;
    assign w_retire_req  = bus.ap_done && w_ap_continue;
    // A retire against an empty FIFO is an error even if a push lands in
    // the same cycle; the new timestamp is never bypassed to the pop.
    assign w_retire      = w_retire_req && !w_empty;
    assign w_retire_err  = w_retire_req && w_empty;

    // Modular subtraction keeps latency correct across cycle_cnt wrap.
    assign w_lat         = r_cycle_cnt - w_head_ts;

    assign w_start_last  = w_accept && ((r_start_cnt + CNT_W'(1)) == r_num_q);
    assign w_done_last   = w_retire && ((r_done_cnt + CNT_W'(1)) == r_num_q);

    assign bus.ap_start    = w_ap_start;
    assign bus.ap_continue = w_ap_continue;

    // ------------------------------------------------------------------
    // Timestamp FIFO: one entry per outstanding transaction.
    // ------------------------------------------------------------------
    ts_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (MAX_OUT)
    ) u_ts_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_go_ok),
        .push      (w_accept),
        .push_data (r_cycle_cnt),
        .pop       (w_retire),
        .head      (w_head_ts),
        .full      (w_full_unused),
        .empty     (w_empty),
        .count     (w_count)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_go_ok) begin
                    w_state_nxt = (num_trans == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // done_cnt can only reach num_q once every start is issued,
                // so RUN leaves only on the last accept; a coincident last
                // retire skips DRAIN entirely.
                if (w_start_last) begin
                    w_state_nxt = w_done_last ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (w_done_last) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, latency extremes and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_num_q     <= '0;
            r_start_cnt <= '0;
            r_done_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_min_lat   <= '1;
            r_max_lat   <= '0;
            r_err       <= 1'b0;
        end else if (w_go_ok) begin
            r_num_q     <= num_trans;
            r_start_cnt <= '0;
            r_done_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_min_lat   <= '1;
            r_max_lat   <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_active) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_start_cnt <= r_start_cnt + CNT_W'(1);
            end
            if (w_retire) begin
                r_done_cnt <= r_done_cnt + CNT_W'(1);
                if (w_lat < r_min_lat) begin
                    r_min_lat <= w_lat;
                end
                if (w_lat > r_max_lat) begin
                    r_max_lat <= w_lat;
                end
            end
            if (w_retire_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy      = w_active;
    assign finish    = (r_state == DONE);
    assign start_cnt = r_start_cnt;
    assign done_cnt  = r_done_cnt;
    assign cycle_cnt = r_cycle_cnt;
    assign min_lat   = r_min_lat;
    assign max_lat   = r_max_lat;
    assign err       = r_err;

endmodule : ap_ctrl_sequencer
`default_nettype wire

// File: tb/tb_ap_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ap_ctrl_sequencer
// Purpose  : Self-checking bench for ap_ctrl_sequencer (CNT_W=8 build so the
//            cycle counter wrap is reachable). A kernel model answers the
//            handshake; every accept pushes its edge index to a scoreboard,
//            every retire pops it and checks done_cnt/min_lat/max_lat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ap_ctrl_sequencer;

    localparam int W  = 8;
    localparam int MO = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         go = 1'b0;
    logic [W-1:0] num_trans = '0;
    logic         sink_ready = 1'b0;
    logic         busy, finish, err;
    logic [W-1:0] start_cnt, done_cnt, cycle_cnt, min_lat, max_lat;

    ap_ctrl_sequencer_if bus ();

    ap_ctrl_sequencer #(
        .CNT_W   (W),
        .MAX_OUT (MO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .go         (go),
        .num_trans  (num_trans),
        .sink_ready (sink_ready),
        .bus        (bus),
        .busy       (busy),
        .finish     (finish),
        .start_cnt  (start_cnt),
        .done_cnt   (done_cnt),
        .cycle_cnt  (cycle_cnt),
        .min_lat    (min_lat),
        .max_lat    (max_lat),
        .err        (err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Kernel controls, written by the main sequence on the falling edge.
    bit rdy_en = 0, done_en = 0, sink_en = 0, force_done = 0;
    int unsigned dly = 5;

    int unsigned n_edge = 0;
    always @(posedge clock) n_edge++;

    // Kernel model + scoreboard
    int unsigned  pend_due[$];
    int unsigned  sb_acc[$];
    logic [W-1:0] m_min = '1, m_max = '0, lat;
    int           m_done = 0;
    bit           acc = 0, ret = 0;

    initial begin : kernel
        int unsigned a;
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                pend_due.delete(); sb_acc.delete();
                m_min = '1; m_max = '0; m_done = 0;
            end else if (ret && sb_acc.size() > 0) begin
                a = sb_acc.pop_front();
                if (pend_due.size() > 0) void'(pend_due.pop_front());
                lat = W'(n_edge - a);
                if (lat < m_min) m_min = lat;
                if (lat > m_max) m_max = lat;
                m_done++;
                chk("retire_done_cnt", done_cnt, m_done);
                chk("retire_min_lat", min_lat, m_min);
                chk("retire_max_lat", max_lat, m_max);
            end
            #1;
            if (go && reset) begin
                pend_due.delete(); sb_acc.delete();
                m_min = '1; m_max = '0; m_done = 0;
            end
            bus.ap_ready = rdy_en;
            bus.ap_done  = force_done;
            if (done_en && pend_due.size() > 0)
                if (pend_due[0] <= n_edge + 1) bus.ap_done = 1'b1;
            sink_ready = sink_en;
            #1;
            acc = reset && bus.ap_start && bus.ap_ready;
            ret = reset && bus.ap_done && bus.ap_continue;
            if (acc) begin
                sb_acc.push_back(n_edge + 1);
                pend_due.push_back(n_edge + 1 + dly);
            end
        end
    end

    task automatic start_run(input logic [W-1:0] n);
        @(negedge clock);
        go = 1'b1; num_trans = n;
        @(negedge clock);
        go = 1'b0;
    endtask

    task automatic wait_finish(input string tag, input int budget);
        for (int i = 0; i < budget && !finish; i++) @(negedge clock);
        chk(tag, finish, 1);
    endtask

    task automatic chk_rst(input string p);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_finish"}, finish, 0);
        chk({p, "_start_cnt"}, start_cnt, 0);
        chk({p, "_done_cnt"}, done_cnt, 0);
        chk({p, "_cycle_cnt"}, cycle_cnt, 0);
        chk({p, "_min_lat"}, min_lat, 32'hFF);
        chk({p, "_max_lat"}, max_lat, 0);
        chk({p, "_err"}, err, 0);
        chk({p, "_ap_start"}, bus.ap_start, 0);
        chk({p, "_ap_continue"}, bus.ap_continue, 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // Reset state
        repeat (3) @(negedge clock);
        chk_rst("reset");
        reset = 1'b1;

        // T1: 3 transactions, immediate ready, done 5 cycles after accept
        rdy_en = 1; done_en = 1; sink_en = 1; dly = 5;
        start_run(3);
        chk("t1_ap_start_cycle1", bus.ap_start, 1);
        chk("t1_busy", busy, 1);
        chk("t1_cycle_cnt0", cycle_cnt, 0);
        wait_finish("t1_finish", 50);
        chk("t1_start_cnt", start_cnt, 3);
        chk("t1_done_cnt", done_cnt, 3);
        chk("t1_min_lat", min_lat, 5);
        chk("t1_max_lat", max_lat, 5);
        chk("t1_err", err, 0);
        chk("t1_busy_done", busy, 0);

        // T2: 8 transactions with ap_done withheld -> stall at MAX_OUT
        done_en = 0; dly = 1;
        start_run(8);
        repeat (10) @(negedge clock);
        chk("t2_start_stall", start_cnt, MO);
        chk("t2_ap_start_low", bus.ap_start, 0);
        chk("t2_done_zero", done_cnt, 0);
        done_en = 1;
        wait_finish("t2_finish", 100);
        chk("t2_start_cnt", start_cnt, 8);
        chk("t2_done_cnt", done_cnt, 8);
        chk("t2_err", err, 0);

        // T3: sink backpressure holds the retire
        sink_en = 0; dly = 1;
        start_run(1);
        repeat (10) begin
            @(negedge clock); #3;
            chk("t3_ap_done_high", bus.ap_done, 1);
            chk("t3_ap_continue_low", bus.ap_continue, 0);
            chk("t3_done_held", done_cnt, 0);
        end
        @(negedge clock);
        sink_en = 1;
        #3 chk("t3_ap_continue_high", bus.ap_continue, 1);
        @(negedge clock);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_finish", finish, 1);

        // T4: zero transactions
        start_run(0);
        chk("t4_finish", finish, 1);
        chk("t4_min_lat", min_lat, 32'hFF);
        chk("t4_busy", busy, 0);
        repeat (3) begin
            @(negedge clock);
            chk("t4_ap_start", bus.ap_start, 0);
        end

        // T5: error retire with empty FIFO, then reset mid-DRAIN
        rdy_en = 0; done_en = 0; sink_en = 1;
        start_run(2);
        force_done = 1;
        @(negedge clock);
        force_done = 0;
        chk("t5_err", err, 1);
        chk("t5_done_unchanged", done_cnt, 0);
        chk("t5_start_unchanged", start_cnt, 0);
        rdy_en = 1;
        repeat (4) @(negedge clock);
        chk("t5_drain_busy", busy, 1);
        chk("t5_drain_starts", start_cnt, 2);
        chk("t5_drain_ap_start", bus.ap_start, 0);
        #3 reset = 1'b0;
        #1 chk_rst("t5_async_reset");
        @(negedge clock);
        reset = 1'b1;

        // T6: latency measured across cycle_cnt wrap
        rdy_en = 0; done_en = 1; sink_en = 1; dly = 4;
        start_run(1);
        repeat (253) @(negedge clock);
        rdy_en = 1;
        wait_finish("t6_finish", 20);
        chk("t6_min_lat", min_lat, 4);
        chk("t6_max_lat", max_lat, 4);
        chk("t6_cycle_wrapped", (cycle_cnt < 8'd16), 1);
        chk("t6_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ap_ctrl_sequencer
`default_nettype wire

// File: doc/ap_ctrl_sequencer.md
# ap_ctrl_sequencer

Drives the block-level ap_ctrl_chain handshake of an HLS kernel (the `hart` top or any sub-function with the same protocol). On a `go` pulse it issues a programmed number of transactions and applies sink backpressure through `ap_continue`. It also measures per-transaction start-to-done latency through a timestamp FIFO and raises `finish` when every issued transaction has retired. It sits between the testbench/host sequencing logic and the kernel. Its `finish` output feeds the dataflow monitor's `finish` input.

## Interface
- `CNT_W`, 32: width of all counters, timestamps and latencies.
- `MAX_OUT`, 4: maximum outstanding transactions (started, not yet retired); power of two, ≥2.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `go` in 1: one-cycle start pulse; ignored unless state is IDLE or DONE.
- `num_trans` in CNT_W: transaction count, sampled when `go` is accepted.
- `sink_ready` in 1: downstream can accept a result.
- `ap_start` out 1: kernel start request.
- `ap_ready` in 1: kernel accepted inputs.
- `ap_done` in 1: kernel result valid.
- `ap_continue` out 1: result consumed.
- `busy` out 1: state is RUN or DRAIN.
- `finish` out 1: level, high in DONE.
- `start_cnt` out CNT_W: accepted starts.
- `done_cnt` out CNT_W: retired transactions.
- `cycle_cnt` out CNT_W: cycles since `go`.
- `min_lat`, `max_lat` out CNT_W: latency extremes over retired transactions.
- `err` out 1: sticky; set when `ap_done` is retired with no outstanding transaction.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **Reset:** state IDLE. All counters, `max_lat` and `err` are 0. `min_lat` is all-ones. FIFO is empty. All outputs are 0 except `min_lat`.
- **IDLE/DONE + `go`:**
  - Latch `num_trans` into `num_q`.
  - Clear counters, FIFO, `err` and the latency extremes.
  - Go to RUN, or to DONE if `num_trans` is 0.
- **`ap_start`:** asserted when state is RUN and `start_cnt` < `num_q` and occupancy < `MAX_OUT`. Driven combinationally from registers only.
- **Start accept:** `ap_start & ap_ready`.
  - Push `cycle_cnt` into the timestamp FIFO.
  - Increment `start_cnt`.
- **`ap_continue`:** equals `sink_ready` when state is RUN or DRAIN, else 0.
- **Retire:** `ap_done & ap_continue` with FIFO non-empty.
  - Pop the head timestamp.
  - Compute `lat = cycle_cnt - ts`, modulo 2^CNT_W.
  - Update `min_lat`/`max_lat` and increment `done_cnt`.
- **Retire with FIFO empty:** set `err`; counters and FIFO are unchanged.
- **Simultaneous push and pop:** both occur in the same cycle; occupancy is unchanged. A pop of an empty FIFO in the same cycle as a push is an error retire, not a bypass.
- **RUN → DRAIN:** when `start_cnt` reaches `num_q`, i.e. on the accept that makes it equal.
- **DRAIN → DONE:** when `done_cnt` reaches `num_q`. If this occurs in the same cycle as RUN → DRAIN, go directly RUN → DONE.
- **DONE:** `finish` held high. Counters are frozen, including `cycle_cnt`. Hold until the next `go`.
- **`cycle_cnt`:** increments every cycle in RUN/DRAIN and wraps silently.

## Timing
- `go` in cycle 0 → state RUN in cycle 1 → `ap_start` high in cycle 1.
- Back-to-back accepts are possible each cycle while occupancy < `MAX_OUT`.
- Counter and FIFO updates are visible the cycle after the accept or retire edge.
- Latency is measured from the accept edge to the retire edge. A kernel with `ap_done` one cycle after `ap_ready` measures 1.
- `finish` rises the cycle after the final retire.
- `reset` asserted mid-run: immediate return to the reset values. `ap_start` and `ap_continue` drop asynchronously.

## Structure
- Package `ap_seq_pkg` contains:
  - `seq_state_t` enum (IDLE, RUN, DRAIN, DONE).
  - Default `CNT_W`.
- Sub-module `ts_fifo`:
  - Parameterised width/depth.
  - Synchronous push/pop.
  - `full`, `empty`, `count` outputs.
  - Same clock and reset.
- Top contains the FSM, counters and latency compare only.

## Test plan
- `num_trans`=3, kernel `ap_ready` immediate, `ap_done` 5 cycles after accept, `sink_ready`=1 → `start_cnt`=`done_cnt`=3, `min_lat`=`max_lat`=5, `finish` high, `err`=0.
- `MAX_OUT`=4, `num_trans`=8, `ap_done` withheld → `ap_start` drops after 4 accepts. Release `ap_done` → all 8 retire.
- `sink_ready`=0 for 10 cycles with `ap_done` high → `ap_continue`=0, no retire, `done_cnt` is held. Raise `sink_ready` → retire in that cycle.
- `num_trans`=0 → DONE one cycle after `go`, `ap_start` never asserted, `min_lat` all-ones.
- `ap_done` pulse in RUN with FIFO empty → `err`=1, `done_cnt` unchanged. `reset` low mid-DRAIN → all outputs return to reset values immediately.
- `cycle_cnt` preset near 2^CNT_W−2 (`CNT_W`=8 build), latency 4 across wrap → `lat` reported as 4.
